down_count_seq: RTL and testbench
=================================

// Module: down_count_seq
// PURPOSE
//  Sequencer directly upstream of down_counter: drives its clr/load/din and watches its count.
//  Each start arms the counter with a captured period, detects terminal count (0), pulses done,
//  and optionally reloads for a programmed number of intervals (0 = free-running until abort).
//  Keeps a saturating count of total expirations for status readback.
// PARAMETERS
//  WIDTH  4  width of period, reps, count and cnt_din; matches down_counter
//  EXP_W  8  width of exp_cnt, the saturating expiration counter
// PORTS
//  clk       in   1      rising-edge clock, shared with down_counter
//  clr       in   1      reset: asynchronous, active-high
//  start     in   1      begin a sequence; sampled only in IDLE
//  abort     in   1      stop an active sequence; no done pulse is produced
//  period    in   WIDTH  counter load value P, captured at start
//  reps      in   WIDTH  number of intervals, captured at start; 0 = run until abort
//  count     in   WIDTH  down_counter count output
//  cnt_clr   out  1      to down_counter clr; combinational
//  cnt_load  out  1      to down_counter load; combinational
//  cnt_din   out  WIDTH  to down_counter din; equals period_q
//  busy      out  1      registered; high while state != IDLE
//  done      out  1      registered; one-cycle pulse per expired interval
//  exp_cnt   out  EXP_W  registered; total done pulses since reset, saturating
// BEHAVIOUR
//  - Reset (clr=1, async): state=IDLE, period_q=0, reps_q=0, rep_cnt=0, busy=0, done=0, exp_cnt=0.
//  - The FSM has three states: IDLE, ARM and RUN. All registers update on the posedge of clk.
//  - IDLE: cnt_clr=1, which parks the counter at all-ones so that a stale 0 is never seen as expiry.
//    * start=1 -> ARM.
//    * At the same edge, capture period_q=period, reps_q=reps, rep_cnt=0.
//  - ARM (exactly 1 cycle): cnt_load=1, cnt_din=period_q. The next edge loads the counter and enters RUN.
//  - RUN: the counter decrements freely. count==0 is the terminal cycle.
//    * In the terminal cycle, last = (reps_q!=0 && rep_cnt+1==reps_q).
//    * If !last: cnt_load=1 in the same cycle, so the counter reloads P instead of wrapping.
//      At the next edge: done=1, rep_cnt++, stay in RUN.
//    * If last: cnt_clr=1 in the same cycle. At the next edge: done=1, state=IDLE, busy=0.
//  - abort=1 in ARM or RUN: cnt_clr=1 in the same cycle, and the next edge enters IDLE.
//    * No done pulse and no exp_cnt change, even when count==0 in that same cycle (abort wins).
//  - start in ARM/RUN is ignored. period and reps changes after capture are ignored.
//  - start and abort together in IDLE: start wins, because abort has no meaning in IDLE.
//  - Timing, with start sampled at edge E0: busy=1 from E0.
//    * First done at edge E0+P+2.
//    * Subsequent done pulses every P+1 cycles.
//    * P=0 yields back-to-back done pulses.
//  - done is high for exactly one cycle per interval and is low in any cycle not following a terminal RUN cycle.
//  - exp_cnt increments with every done and holds at 2^EXP_W-1. rep_cnt wraps only when reps_q=0 (endless mode).
//  - All count widths are unsigned WIDTH bits. Never compare count against the wider rep arithmetic.
//  - cnt_clr and cnt_load are never both 1 in the same cycle.
// TESTING
//  1. P=3, reps=1, start at E0:
//     -> cnt_load=1 in the ARM cycle; count 3,2,1,0; done=1 only after E5; busy falls at E5; exp_cnt=1.
//  2. P=2, reps=3:
//     -> three done pulses at E4, E7, E10; count never shows all-ones between intervals; IDLE after E10; exp_cnt=3.
//  3. P=0, reps=2:
//     -> done high after E2 and E3 (back-to-back); then IDLE with cnt_clr=1.
//  4. reps=0, P=1, abort asserted two cycles after the 2nd done:
//     -> cnt_clr=1 that cycle; IDLE next edge; no 3rd done; exp_cnt=2.
//  5. abort coincident with count==0; start pulsed while busy:
//     -> no done and exp_cnt unchanged; the mid-run start has no effect on period_q or the interval.
//  6. clr asserted mid-RUN between edges:
//     -> busy, done and exp_cnt go to 0 immediately; cnt_clr=1. With EXP_W=2 and reps=0, P=0,
//        exp_cnt saturates at 3.

Source files
------------

// File: rtl/down_count_seq_if.sv
// down_count_seq_if: control and down_counter-facing signals of the down_count_seq sequencer
//  master: start/abort/period/reps/count driven, status and counter controls observed
//  slave : the sequencer's view (down_count_seq)
interface down_count_seq_if #(
  parameter int WIDTH = 4,
  parameter int EXP_W = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] reps;
  logic [WIDTH-1:0] count;
  logic             cnt_clr;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_din;
  logic             busy;
  logic             done;
  logic [EXP_W-1:0] exp_cnt;
  modport master (
    output start, abort, period, reps, count,
    input  cnt_clr, cnt_load, cnt_din, busy, done, exp_cnt
  );
  modport slave (
    input  start, abort, period, reps, count,
    output cnt_clr, cnt_load, cnt_din, busy, done, exp_cnt
  );
endinterface

// File: rtl/down_count_seq.sv
// down_count_seq: arms a down_counter with a captured period, pulses done at each terminal count,
//  reloads for a programmed number of intervals (0 = until abort), counts expirations (saturating).
//  clk  : rising-edge clock shared with the down_counter
//  clr  : asynchronous active-high reset
//  bus  : slave side of down_count_seq_if
//         in  start, abort, period, reps, count
//         out cnt_clr, cnt_load (combinational), cnt_din (= period_q),
//             busy, done, exp_cnt (registered)
module down_count_seq #(
  parameter int WIDTH = 4,
  parameter int EXP_W = 8
) (
  input logic             clk,
  input logic             clr,
  down_count_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] reps_q, reps_d;
  logic [WIDTH-1:0] rep_cnt_q, rep_cnt_d;
  logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rep_nxt;
  logic             cap, term, last, cnt_clr, cnt_load;
  always_comb begin
    cap       = state_q == IDLE && bus.start;
    rep_nxt   = rep_cnt_q + WIDTH'(1);
    // abort outranks a coincident terminal count: no done, no reload
    term      = state_q == RUN && bus.count == '0 && !bus.abort;
    last      = reps_q != '0 && rep_nxt == reps_q;
    // IDLE parks the counter at all-ones so a stale zero never reads as expiry
    cnt_clr   = state_q == IDLE || bus.abort || (term && last);
    cnt_load  = !cnt_clr && (state_q == ARM || term);
    state_d   = state_q == IDLE ? (bus.start ? ARM : IDLE)
              : (bus.abort || (term && last)) ? IDLE : RUN;
    period_d  = cap ? bus.period : period_q;
    reps_d    = cap ? bus.reps : reps_q;
    rep_cnt_d = cap ? '0 : (term && !last) ? rep_nxt : rep_cnt_q;
    exp_cnt_d = (term && exp_cnt_q != '1) ? exp_cnt_q + EXP_W'(1) : exp_cnt_q;
    done_d    = term;
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      period_q  <= '0;
      reps_q    <= '0;
      rep_cnt_q <= '0;
      exp_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      reps_q    <= reps_d;
      rep_cnt_q <= rep_cnt_d;
      exp_cnt_q <= exp_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign bus.cnt_clr  = cnt_clr;
  assign bus.cnt_load = cnt_load;
  assign bus.cnt_din  = period_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.exp_cnt  = exp_cnt_q;
endmodule

// File: tb/tb_down_count_seq.sv
// tb_down_count_seq: randomized self-checking bench for down_count_seq against an interval-arithmetic model
module tb_down_count_seq;
  localparam int NONE = 1 << 30;
  logic clk, clr, start, abort;
  logic [3:0] period, reps, cnt1, cnt2;
  int errors, checks, n_done;

  down_count_seq_if #(.WIDTH(4), .EXP_W(8)) bus ();
  down_count_seq_if #(.WIDTH(4), .EXP_W(2)) bus2 ();
  down_count_seq #(.WIDTH(4), .EXP_W(8)) dut  (.clk(clk), .clr(clr), .bus(bus));
  down_count_seq #(.WIDTH(4), .EXP_W(2)) dut2 (.clk(clk), .clr(clr), .bus(bus2));

  assign bus.start  = start;
  assign bus.abort  = abort;
  assign bus.period = period;
  assign bus.reps   = reps;
  assign bus.count  = cnt1;
  assign bus2.start  = start;
  assign bus2.abort  = abort;
  assign bus2.period = period;
  assign bus2.reps   = reps;
  assign bus2.count  = cnt2;

  // behavioural down_counter: clr -> all-ones, load -> din, else decrement with wrap
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt1 <= '1;
      cnt2 <= '1;
    end else begin
      cnt1 <= bus.cnt_clr ? '1 : bus.cnt_load ? bus.cnt_din : cnt1 - 4'd1;
      cnt2 <= bus2.cnt_clr ? '1 : bus2.cnt_load ? bus2.cnt_din : cnt2 - 4'd1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One sequence: start sampled at edge E0; cycle k lies between edges E0+k and E0+k+1.
  // Intervals last p+1 cycles; terminal cycles are k = j*(p+1), j>=1; done follows each one.
  // ak: cycle carrying abort; ck: cycle in which clr is pulsed mid-cycle.
  task automatic run_seq(input int p, input int r, input int ak, input int ck, input bit noise, input bit ab0);
    int endk, j;
    bit st_busy, term, last, ab, exp_done, exp_clr, exp_load;
    logic [3:0] ecount;
    endk = (r == 0) ? NONE : r * (p + 1) + 1;
    @(posedge clk); #1;
    start = 1'b1; abort = ab0; period = 4'(p); reps = 4'(r);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL idle_done got=%0b exp=0", bus.done); end
    checks++; if ({bus.cnt_clr, bus.cnt_load} !== 2'b10) begin errors++; $display("FAIL idle_clr_load got=%b exp=10", {bus.cnt_clr, bus.cnt_load}); end
    for (int k = 0; k < 700; k++) begin
      st_busy = k < endk && k <= ak;
      @(posedge clk); #1;
      abort  = k == ak;
      start  = noise && st_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      period = noise ? 4'($urandom) : 4'(p);
      reps   = noise ? 4'($urandom) : 4'(r);
      @(negedge clk);
      j        = k / (p + 1);
      term     = st_busy && k >= p + 1 && k % (p + 1) == 0;
      last     = r != 0 && j == r;
      ab       = st_busy && k == ak;
      exp_done = k >= p + 2 && (k - 1) % (p + 1) == 0 && (r == 0 || (k - 1) / (p + 1) <= r) && k - 1 < ak;
      exp_clr  = !st_busy || ab || (term && last);
      exp_load = st_busy && !ab && (k == 0 || (term && !last));
      ecount   = k == 0 ? 4'hf : 4'(p - (k - 1) % (p + 1));
      if (exp_done) n_done++;
      checks++; if (bus.busy !== st_busy) begin errors++; $display("FAIL busy p=%0d r=%0d k=%0d got=%0b exp=%0b", p, r, k, bus.busy, st_busy); end
      checks++; if (bus.done !== exp_done) begin errors++; $display("FAIL done p=%0d r=%0d k=%0d got=%0b exp=%0b", p, r, k, bus.done, exp_done); end
      checks++; if (bus2.done !== exp_done) begin errors++; $display("FAIL done2 p=%0d r=%0d k=%0d got=%0b exp=%0b", p, r, k, bus2.done, exp_done); end
      checks++; if (bus.cnt_clr !== exp_clr) begin errors++; $display("FAIL cnt_clr p=%0d r=%0d k=%0d got=%0b exp=%0b", p, r, k, bus.cnt_clr, exp_clr); end
      checks++; if (bus.cnt_load !== exp_load) begin errors++; $display("FAIL cnt_load p=%0d r=%0d k=%0d got=%0b exp=%0b", p, r, k, bus.cnt_load, exp_load); end
      checks++; if (bus.exp_cnt !== 8'(n_done > 255 ? 255 : n_done)) begin errors++; $display("FAIL exp_cnt k=%0d got=%0d exp=%0d", k, bus.exp_cnt, n_done > 255 ? 255 : n_done); end
      checks++; if (bus2.exp_cnt !== 2'(n_done > 3 ? 3 : n_done)) begin errors++; $display("FAIL exp_cnt2 k=%0d got=%0d exp=%0d", k, bus2.exp_cnt, n_done > 3 ? 3 : n_done); end
      if (st_busy) begin
        checks++; if (bus.cnt_din !== 4'(p)) begin errors++; $display("FAIL cnt_din k=%0d got=%0d exp=%0d", k, bus.cnt_din, p); end
        checks++; if (cnt1 !== ecount) begin errors++; $display("FAIL count p=%0d r=%0d k=%0d got=%0d exp=%0d", p, r, k, cnt1, ecount); end
      end
      if (k == ck) begin
        #2 clr = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.done, bus.exp_cnt, bus2.exp_cnt} !== 12'b0) begin errors++; $display("FAIL async_clr got=%0h exp=0", {bus.busy, bus.done, bus.exp_cnt, bus2.exp_cnt}); end
        checks++; if ({bus.cnt_clr, bus.cnt_load} !== 2'b10) begin errors++; $display("FAIL async_clr_cnt got=%b exp=10", {bus.cnt_clr, bus.cnt_load}); end
        n_done = 0;
        #1 clr = 1'b0;
        start = 1'b0; abort = 1'b0;
        return;
      end
      if (!st_busy) return;
    end
    errors++; checks++;
    $display("FAIL timeout p=%0d r=%0d sequence never returned to idle", p, r);
  endtask

  task automatic test_reset;
    #1;
    checks++; if ({bus.busy, bus.done, bus.exp_cnt} !== 10'b0) begin errors++; $display("FAIL reset_status got=%0h exp=0", {bus.busy, bus.done, bus.exp_cnt}); end
    checks++; if ({bus.cnt_clr, bus.cnt_load} !== 2'b10) begin errors++; $display("FAIL reset_cnt_ctrl got=%b exp=10", {bus.cnt_clr, bus.cnt_load}); end
    checks++; if (bus.cnt_din !== 4'd0) begin errors++; $display("FAIL reset_din got=%0d exp=0", bus.cnt_din); end
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic test_single;        run_seq(3, 1, NONE, NONE, 1'b0, 1'b0); endtask
  task automatic test_multi;         run_seq(2, 3, NONE, NONE, 1'b0, 1'b0); endtask
  task automatic test_zero_period;   run_seq(0, 2, NONE, NONE, 1'b0, 1'b0); endtask
  task automatic test_endless_abort; run_seq(1, 0, 6, NONE, 1'b0, 1'b0); endtask
  task automatic test_idle_start_abort; run_seq(2, 1, NONE, NONE, 1'b0, 1'b1); endtask
  task automatic test_saturate;      run_seq(0, 0, 280, NONE, 1'b0, 1'b0); endtask
  task automatic test_async_clr;     run_seq(0, 0, NONE, 8, 1'b0, 1'b0); endtask

  task automatic test_abort_at_zero;
    run_seq(4, 0, 5, NONE, 1'b1, 1'b0);
    run_seq(4, 2, 10, NONE, 1'b1, 1'b0);
    run_seq(3, 2, 0, NONE, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    int p, r, ak;
    for (int i = 0; i < 25; i++) begin
      p  = $urandom_range(0, 15);
      r  = $urandom_range(0, 8);
      ak = (r == 0 || $urandom_range(0, 2) == 0) ? $urandom_range(0, 50) : NONE;
      run_seq(p, r, ak, NONE, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    errors = 0; checks = 0; n_done = 0;
    clr = 1'b1; start = 1'b0; abort = 1'b0; period = '0; reps = '0;
    test_reset;
    test_single;
    test_multi;
    test_zero_period;
    test_endless_abort;
    test_abort_at_zero;
    test_idle_start_abort;
    test_saturate;
    test_async_clr;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
